rs_scheduler: RTL and testbench
===============================

RS_SCHEDULER -- requirements
Module: rs_scheduler

Interface
REQ-001 SHALL have parameter RS_SIZE, default 16, number of station entries (power of two, 2..32).
REQ-002 SHALL have parameter RS_LOG, default 4, equal to log2(RS_SIZE).
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port rdy  input  1  global enable; low freezes all state and registered outputs.
REQ-006 SHALL have port clear  input  1  misprediction flush.
REQ-007 SHALL have port D_valid  input  1  dispatch strobe from decoder.
REQ-008 SHALL have ports D_op  input  OP_LOG, D_Imm  input  32, D_CurPC  input  32, D_DestRob  input  ROB_LOG  dispatched instruction fields.
REQ-009 SHALL have ports D_Vj/D_Vk  input  32, D_Qj/D_Qk  input  ROB_LOG, D_Jbusy/D_Kbusy  input  1  operand value or producing ROB tag (busy=1 means waiting on tag).
REQ-010 SHALL have ports A_enable  input  1, A_RobId  input  ROB_LOG, A_value  input  32  ALU result broadcast.
REQ-011 SHALL have ports L_enable  input  1, L_RobId  input  ROB_LOG, L_value  input  32  load-store result broadcast.
REQ-012 SHALL have port RS_full  output  1  registered; high when free entries < 2.
REQ-013 SHALL have ports RS_valid  output  1, RS_op  output  OP_LOG, RS_Vj/RS_Vk/RS_Imm/RS_CurPC  output  32, RS_DestRob  output  ROB_LOG  registered issue to the functional unit.

Function
REQ-014 SHALL store per entry: busy, op, Vj, Vk, Jbusy, Kbusy, Qj, Qk, Imm, CurPC, DestRob.
REQ-015 SHALL write a dispatch into the lowest-index free entry on the edge where D_valid=1; decoder honours RS_full, dispatch into a full station SHALL be dropped.
REQ-016 SHALL, on each edge, clear Jbusy (load Vj) in every busy entry whose Qj matches an enabled A or L broadcast; same for K side.
REQ-017 SHALL bypass broadcasts into the dispatched entry: if D_Jbusy=1 and D_Qj matches an enabled broadcast that cycle, store Jbusy=0 with broadcast value; same for K side.
REQ-018 SHALL treat an entry as ready when busy=1, Jbusy=0, Kbusy=0 at cycle start; broadcasts and dispatch in the current cycle do not make it ready until next cycle.
REQ-019 SHALL select one ready entry per cycle, register its fields onto RS_* with RS_valid=1 and free it on the same edge; no ready entry gives RS_valid=0.
REQ-020 SHALL give issue latency of one cycle from ready to RS_valid; dependent instruction issues two cycles after its producer.
REQ-021 SHALL allow a freed entry to be reused by dispatch on the following edge, not the same edge.
REQ-022 SHALL, when A and L broadcast the same RobId, take A_value.
REQ-023 SHALL recompute RS_full each edge from post-update occupancy (includes same-edge dispatch and issue).
REQ-024 SHALL, on clear=1 with rdy=1, invalidate all entries, drop same-cycle dispatch, drive RS_valid=0 next cycle; clear overrides dispatch and issue.
REQ-025 SHALL, with rdy=0, ignore dispatch, broadcasts and clear, holding RS_* and RS_full unchanged.

Reset
REQ-026 SHALL, on rst=1 at an edge, clear all busy bits, RS_valid=0, RS_full=0, all other RS_* outputs 0; rst overrides rdy and clear.
REQ-027 SHALL accept dispatch on the first edge after rst deasserts.

Configuration
REQ-028 SHALL compile an age-ordered selector when RS_AGE_SEL_EN is defined: choose oldest ready entry by dispatch order (per-entry age tracking, cleared on free/clear/reset).
REQ-029 SHALL, without RS_AGE_SEL_EN, choose lowest-index ready entry; all other behaviour identical.

Verification
REQ-030 SHALL test: dispatch ADD Vj=5 Vk=7 ready, DestRob=3 -> next edge RS_valid=1, RS_Vj=5, RS_Vk=7, RS_DestRob=3; following cycle RS_valid=0.
REQ-031 SHALL test: dispatch entry Jbusy Qj=2, then A_enable RobId=2 value=0x10 -> issue two edges after broadcast with RS_Vj=0x10.
REQ-032 SHALL test: D_Qj=4 dispatched same cycle as L_enable RobId=4 value=9 -> entry issues next cycle with RS_Vj=9 (bypass).
REQ-033 SHALL test: 15 unready dispatches -> RS_full=1 after 15th; 16th dispatch accepted; 17th dropped.
REQ-034 SHALL test: three ready entries then clear=1 -> RS_valid=0 next cycle, no further issue, RS_full=0.
REQ-035 SHALL test: entries dispatched into index 5 then index 1 both woken same cycle -> with RS_AGE_SEL_EN index 5 issues first, without it index 1 first.

Source files
------------

// File: rtl/rs_scheduler.sv
// Reservation station: tag wakeup from ALU/load-store broadcasts, one issue per cycle.
// Define RS_AGE_SEL_EN to issue the oldest ready entry instead of the lowest-index one.
module rs_scheduler #(
  parameter int RS_SIZE = 16,
  parameter int RS_LOG  = 4,
  parameter int OP_LOG  = 4,
  parameter int ROB_LOG = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               clear,
  input  logic               D_valid,
  input  logic [OP_LOG-1:0]  D_op,
  input  logic [31:0]        D_Imm,
  input  logic [31:0]        D_CurPC,
  input  logic [ROB_LOG-1:0] D_DestRob,
  input  logic [31:0]        D_Vj,
  input  logic [31:0]        D_Vk,
  input  logic [ROB_LOG-1:0] D_Qj,
  input  logic [ROB_LOG-1:0] D_Qk,
  input  logic               D_Jbusy,
  input  logic               D_Kbusy,
  input  logic               A_enable,
  input  logic [ROB_LOG-1:0] A_RobId,
  input  logic [31:0]        A_value,
  input  logic               L_enable,
  input  logic [ROB_LOG-1:0] L_RobId,
  input  logic [31:0]        L_value,
  output logic               RS_full,
  output logic               RS_valid,
  output logic [OP_LOG-1:0]  RS_op,
  output logic [31:0]        RS_Vj,
  output logic [31:0]        RS_Vk,
  output logic [31:0]        RS_Imm,
  output logic [31:0]        RS_CurPC,
  output logic [ROB_LOG-1:0] RS_DestRob
);

  logic [RS_SIZE-1:0] busy, jbusy, kbusy, ready, next_busy;
  logic [OP_LOG-1:0]  op_q   [RS_SIZE];
  logic [31:0]        vj_q   [RS_SIZE];
  logic [31:0]        vk_q   [RS_SIZE];
  logic [31:0]        imm_q  [RS_SIZE];
  logic [31:0]        pc_q   [RS_SIZE];
  logic [ROB_LOG-1:0] qj_q   [RS_SIZE];
  logic [ROB_LOG-1:0] qk_q   [RS_SIZE];
  logic [ROB_LOG-1:0] dest_q [RS_SIZE];

  logic [RS_LOG-1:0] free_idx, sel_idx;
  logic              has_free, has_ready, do_dispatch, full_next;
  logic              d_jbusy, d_kbusy;
  logic [31:0]       d_vj, d_vk;
  int                occ;

  assign ready       = busy & ~jbusy & ~kbusy;
  assign has_ready   = |ready;
  assign do_dispatch = D_valid && has_free;

  always_comb begin
    free_idx = '0;
    has_free = 1'b0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_idx = RS_LOG'(i);
        has_free = 1'b1;
      end
    end
  end

  // Same-cycle broadcast bypass for the dispatched operands; ALU wins on a tag tie.
  always_comb begin
    d_jbusy = D_Jbusy;
    d_vj    = D_Vj;
    if (D_Jbusy && A_enable && D_Qj == A_RobId) begin
      d_jbusy = 1'b0;
      d_vj    = A_value;
    end else if (D_Jbusy && L_enable && D_Qj == L_RobId) begin
      d_jbusy = 1'b0;
      d_vj    = L_value;
    end
    d_kbusy = D_Kbusy;
    d_vk    = D_Vk;
    if (D_Kbusy && A_enable && D_Qk == A_RobId) begin
      d_kbusy = 1'b0;
      d_vk    = A_value;
    end else if (D_Kbusy && L_enable && D_Qk == L_RobId) begin
      d_kbusy = 1'b0;
      d_vk    = L_value;
    end
  end

`ifdef RS_AGE_SEL_EN
  // older[i][j] is set when entry i was dispatched before entry j.
  logic [RS_SIZE-1:0] older [RS_SIZE];
  logic [RS_SIZE-1:0] blocked;

  always_comb begin
    blocked = '0;
    sel_idx = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      for (int j = 0; j < RS_SIZE; j++) begin
        if (ready[j] && older[j][i]) blocked[i] = 1'b1;
      end
    end
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (ready[i] && !blocked[i]) sel_idx = RS_LOG'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RS_SIZE; i++) older[i] <= '0;
    end else if (rdy) begin
      if (clear) begin
        for (int i = 0; i < RS_SIZE; i++) older[i] <= '0;
      end else begin
        if (has_ready) begin
          older[sel_idx] <= '0;
          for (int j = 0; j < RS_SIZE; j++) older[j][sel_idx] <= 1'b0;
        end
        if (do_dispatch) begin
          older[free_idx] <= '0;
          for (int j = 0; j < RS_SIZE; j++)
            older[j][free_idx] <= next_busy[j] && (RS_LOG'(j) != free_idx);
        end
      end
    end
  end
`else
  always_comb begin
    sel_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (ready[i]) sel_idx = RS_LOG'(i);
    end
  end
`endif

  always_comb begin
    next_busy = busy;
    if (has_ready) next_busy[sel_idx] = 1'b0;
    if (do_dispatch) next_busy[free_idx] = 1'b1;
    occ = 0;
    for (int i = 0; i < RS_SIZE; i++) occ = occ + int'(next_busy[i]);
    full_next = (occ > RS_SIZE - 2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= '0;
      RS_valid   <= 1'b0;
      RS_full    <= 1'b0;
      RS_op      <= '0;
      RS_Vj      <= '0;
      RS_Vk      <= '0;
      RS_Imm     <= '0;
      RS_CurPC   <= '0;
      RS_DestRob <= '0;
    end else if (rdy) begin
      if (clear) begin
        busy     <= '0;
        RS_valid <= 1'b0;
        RS_full  <= 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy[i] && jbusy[i]) begin
            if (A_enable && qj_q[i] == A_RobId) begin
              jbusy[i] <= 1'b0;
              vj_q[i]  <= A_value;
            end else if (L_enable && qj_q[i] == L_RobId) begin
              jbusy[i] <= 1'b0;
              vj_q[i]  <= L_value;
            end
          end
          if (busy[i] && kbusy[i]) begin
            if (A_enable && qk_q[i] == A_RobId) begin
              kbusy[i] <= 1'b0;
              vk_q[i]  <= A_value;
            end else if (L_enable && qk_q[i] == L_RobId) begin
              kbusy[i] <= 1'b0;
              vk_q[i]  <= L_value;
            end
          end
        end
        RS_valid <= has_ready;
        if (has_ready) begin
          RS_op      <= op_q[sel_idx];
          RS_Vj      <= vj_q[sel_idx];
          RS_Vk      <= vk_q[sel_idx];
          RS_Imm     <= imm_q[sel_idx];
          RS_CurPC   <= pc_q[sel_idx];
          RS_DestRob <= dest_q[sel_idx];
        end
        if (do_dispatch) begin
          op_q[free_idx]   <= D_op;
          imm_q[free_idx]  <= D_Imm;
          pc_q[free_idx]   <= D_CurPC;
          dest_q[free_idx] <= D_DestRob;
          qj_q[free_idx]   <= D_Qj;
          qk_q[free_idx]   <= D_Qk;
          jbusy[free_idx]  <= d_jbusy;
          kbusy[free_idx]  <= d_kbusy;
          vj_q[free_idx]   <= d_vj;
          vk_q[free_idx]   <= d_vk;
        end
        busy    <= next_busy;
        RS_full <= full_next;
      end
    end
  end

endmodule

// File: tb/tb_rs_scheduler.sv
// Scoreboard bench for rs_scheduler: expected issues are queued at dispatch and popped on RS_valid.
module tb_rs_scheduler;

  logic        clk = 1'b0;
  logic        rst, rdy, clear;
  logic        D_valid, D_Jbusy, D_Kbusy;
  logic [3:0]  D_op, D_DestRob, D_Qj, D_Qk;
  logic [31:0] D_Imm, D_CurPC, D_Vj, D_Vk;
  logic        A_enable, L_enable;
  logic [3:0]  A_RobId, L_RobId;
  logic [31:0] A_value, L_value;
  logic        RS_full, RS_valid;
  logic [3:0]  RS_op, RS_DestRob;
  logic [31:0] RS_Vj, RS_Vk, RS_Imm, RS_CurPC;

  typedef struct {
    logic [31:0] vj;
    logic [31:0] vk;
    logic [31:0] imm;
    logic [3:0]  dest;
  } exp_t;

  exp_t expq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic rdy_q    = 1'b0;

  rs_scheduler dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .D_valid(D_valid), .D_op(D_op), .D_Imm(D_Imm), .D_CurPC(D_CurPC), .D_DestRob(D_DestRob),
    .D_Vj(D_Vj), .D_Vk(D_Vk), .D_Qj(D_Qj), .D_Qk(D_Qk), .D_Jbusy(D_Jbusy), .D_Kbusy(D_Kbusy),
    .A_enable(A_enable), .A_RobId(A_RobId), .A_value(A_value),
    .L_enable(L_enable), .L_RobId(L_RobId), .L_value(L_value),
    .RS_full(RS_full), .RS_valid(RS_valid), .RS_op(RS_op), .RS_Vj(RS_Vj), .RS_Vk(RS_Vk),
    .RS_Imm(RS_Imm), .RS_CurPC(RS_CurPC), .RS_DestRob(RS_DestRob)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) rdy_q <= rdy;

  // A new issue is only produced on edges where the station was enabled.
  always @(negedge clk) begin
    if (rdy_q && RS_valid) begin
      if (expq.size() == 0) begin
        checkOutput("unexpected_issue", {28'd0, RS_DestRob}, 32'hffff_ffff);
      end else begin
        exp_t e;
        e = expq.pop_front();
        checkOutput("issue_vj",   RS_Vj, e.vj);
        checkOutput("issue_vk",   RS_Vk, e.vk);
        checkOutput("issue_imm",  RS_Imm, e.imm);
        checkOutput("issue_pc",   RS_CurPC, e.imm + 32'h1000);
        checkOutput("issue_op",   {28'd0, RS_op}, {28'd0, e.imm[3:0]});
        checkOutput("issue_dest", {28'd0, RS_DestRob}, {28'd0, e.dest});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushExp(input logic [31:0] vj, input logic [31:0] vk,
                         input logic [31:0] imm, input logic [3:0] dest);
    exp_t e;
    e.vj = vj; e.vk = vk; e.imm = imm; e.dest = dest;
    expq.push_back(e);
  endtask

  task automatic applyStimulus(input logic jb, input logic [3:0] qj, input logic [31:0] vj,
                               input logic kb, input logic [3:0] qk, input logic [31:0] vk,
                               input logic [31:0] imm, input logic [3:0] dest);
    D_valid = 1'b1; D_Jbusy = jb; D_Qj = qj; D_Vj = vj;
    D_Kbusy = kb; D_Qk = qk; D_Vk = vk;
    D_Imm = imm; D_CurPC = imm + 32'h1000; D_op = imm[3:0]; D_DestRob = dest;
    tick();
    D_valid = 1'b0;
  endtask

  task automatic broadcast(input logic ua, input logic ul, input logic [3:0] rob,
                           input logic [31:0] av, input logic [31:0] lv);
    A_enable = ua; A_RobId = rob; A_value = av;
    L_enable = ul; L_RobId = rob; L_value = lv;
    tick();
    A_enable = 1'b0; L_enable = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; clear = 1'b0;
    D_valid = 0; D_Jbusy = 0; D_Kbusy = 0; D_op = 0; D_DestRob = 0; D_Qj = 0; D_Qk = 0;
    D_Imm = 0; D_CurPC = 0; D_Vj = 0; D_Vk = 0;
    A_enable = 0; L_enable = 0; A_RobId = 0; L_RobId = 0; A_value = 0; L_value = 0;
    tick(); tick();
    rst = 1'b0;
    checkOutput("reset_valid", {31'd0, RS_valid}, 32'd0);
    checkOutput("reset_full",  {31'd0, RS_full}, 32'd0);
    checkOutput("reset_vj",    RS_Vj, 32'd0);
    checkOutput("reset_dest",  {28'd0, RS_DestRob}, 32'd0);

    // Ready ADD dispatched right after reset, issues on the next edge.
    pushExp(32'd5, 32'd7, 32'd1, 4'd3);
    applyStimulus(1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd7, 32'd1, 4'd3);
    tick();
    checkOutput("add_valid_hi", {31'd0, RS_valid}, 32'd1);
    tick();
    checkOutput("add_valid_lo", {31'd0, RS_valid}, 32'd0);

    // Wakeup by ALU broadcast.
    pushExp(32'h10, 32'd1, 32'd2, 4'd4);
    applyStimulus(1'b1, 4'd2, 32'd0, 1'b0, 4'd0, 32'd1, 32'd2, 4'd4);
    tick();
    checkOutput("wait_valid", {31'd0, RS_valid}, 32'd0);
    broadcast(1'b1, 1'b0, 4'd2, 32'h10, 32'd0);
    checkOutput("wake_edge_valid", {31'd0, RS_valid}, 32'd0);
    tick();
    checkOutput("wake_issue_valid", {31'd0, RS_valid}, 32'd1);
    checkOutput("wake_issue_vj", RS_Vj, 32'h10);
    tick();

    // Load-store broadcast bypassed into the dispatching entry.
    pushExp(32'd9, 32'd2, 32'd3, 4'd5);
    L_enable = 1'b1; L_RobId = 4'd4; L_value = 32'd9;
    applyStimulus(1'b1, 4'd4, 32'd0, 1'b0, 4'd0, 32'd2, 32'd3, 4'd5);
    L_enable = 1'b0;
    tick();
    checkOutput("bypass_valid", {31'd0, RS_valid}, 32'd1);
    tick();

    // ALU and load-store broadcast the same tag: ALU value wins (K side).
    pushExp(32'd4, 32'h55, 32'd4, 4'd6);
    applyStimulus(1'b0, 4'd0, 32'd4, 1'b1, 4'd6, 32'd0, 32'd4, 4'd6);
    broadcast(1'b1, 1'b1, 4'd6, 32'h55, 32'h66);
    tick(); tick();

    // rdy low freezes issue, ignores dispatch, and holds outputs.
    pushExp(32'd11, 32'd12, 32'd5, 4'd7);
    applyStimulus(1'b0, 4'd0, 32'd11, 1'b0, 4'd0, 32'd12, 32'd5, 4'd7);
    rdy = 1'b0;
    tick();
    checkOutput("frozen_no_issue", {31'd0, RS_valid}, 32'd0);
    rdy = 1'b1;
    tick();
    checkOutput("unfrozen_issue", {31'd0, RS_valid}, 32'd1);
    rdy = 1'b0;
    D_valid = 1'b1; D_Jbusy = 1'b0; D_Kbusy = 1'b0; D_Vj = 32'd99; D_Imm = 32'd99;
    tick(); tick();
    D_valid = 1'b0;
    checkOutput("hold_valid", {31'd0, RS_valid}, 32'd1);
    checkOutput("hold_vj", RS_Vj, 32'd11);
    rdy = 1'b1;
    tick();
    checkOutput("after_hold_valid", {31'd0, RS_valid}, 32'd0);

    // Fill the station: full after 15, 16th accepted, 17th dropped.
    for (int i = 1; i <= 17; i++) begin
      if (i <= 16) pushExp(32'h77, 32'(i), 32'(i), 4'(i));
      applyStimulus(1'b1, 4'd15, 32'd0, 1'b0, 4'd0, 32'(i), 32'(i), 4'(i));
      if (i == 14) checkOutput("full_at_14", {31'd0, RS_full}, 32'd0);
      if (i >= 15) checkOutput("full_at_15plus", {31'd0, RS_full}, 32'd1);
    end
    broadcast(1'b1, 1'b0, 4'd15, 32'h77, 32'd0);
    for (int i = 0; i < 20; i++) tick();
    checkOutput("drained_full", {31'd0, RS_full}, 32'd0);
    checkOutput("drained_queue", expq.size(), 32'd0);

    // Three ready entries flushed by clear before any issues.
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 4'd3, 32'd0, 1'b0, 4'd0, 32'd1, 32'd50 + 32'(i), 4'd1);
    broadcast(1'b1, 1'b0, 4'd3, 32'h33, 32'd0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checkOutput("clear_valid", {31'd0, RS_valid}, 32'd0);
    checkOutput("clear_full",  {31'd0, RS_full}, 32'd0);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("clear_no_issue", {31'd0, RS_valid}, 32'd0);

    // Index 5 dispatched before index 1, both woken together.
    for (int i = 0; i < 6; i++) begin
      logic [3:0] tag;
      tag = (i == 1) ? 4'd9 : (i == 5) ? 4'd7 : 4'd8;
      applyStimulus(1'b1, tag, 32'd0, 1'b0, 4'd0, 32'd100 + 32'(i), 32'd100 + 32'(i), 4'(i));
    end
    pushExp(32'h90, 32'd101, 32'd101, 4'd1);
    broadcast(1'b1, 1'b0, 4'd9, 32'h90, 32'd0);
    tick(); tick();
    applyStimulus(1'b1, 4'd7, 32'd0, 1'b0, 4'd0, 32'd200, 32'd200, 4'd8);
`ifdef RS_AGE_SEL_EN
    pushExp(32'h70, 32'd105, 32'd105, 4'd5);
    pushExp(32'h70, 32'd200, 32'd200, 4'd8);
`else
    pushExp(32'h70, 32'd200, 32'd200, 4'd8);
    pushExp(32'h70, 32'd105, 32'd105, 4'd5);
`endif
    broadcast(1'b1, 1'b0, 4'd7, 32'h70, 32'd0);
    tick(); tick(); tick();
    pushExp(32'h80, 32'd100, 32'd100, 4'd0);
    pushExp(32'h80, 32'd102, 32'd102, 4'd2);
    pushExp(32'h80, 32'd103, 32'd103, 4'd3);
    pushExp(32'h80, 32'd104, 32'd104, 4'd4);
    broadcast(1'b1, 1'b0, 4'd8, 32'h80, 32'd0);
    for (int i = 0; i < 8; i++) tick();
    checkOutput("final_queue", expq.size(), 32'd0);
    checkOutput("final_full", {31'd0, RS_full}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
